kmap_sweep_checker: RTL and testbench
=====================================

KMAP_SWEEP_CHECKER -- requirements
Module: kmap_sweep_checker

Interface
REQ-001 Parameter N_IN, default 3: width of the stimulus vector driven to the device under test (DUT).
REQ-002 Parameter SETTLE, default 2: idle cycles per vector before the DUT output is sampled; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a full sweep; accepted only in IDLE.
REQ-006 abort  input  1  cancel a sweep in progress.
REQ-007 expected  input  2**N_IN  expected truth table; bit i is the expected DUT output for stim == i; latched on start accept.
REQ-008 dut_out  input  1  DUT combinational output.
REQ-009 stim  output  N_IN  DUT input vector, MSB first ({a,b,c} for N_IN=3).
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 captured  output  2**N_IN  truth table observed on dut_out.
REQ-014 err_count  output  N_IN+1  number of mismatching vectors.
REQ-015 first_err  output  N_IN  lowest stim index that mismatched.
REQ-016 first_err_valid  output  1  first_err holds a valid index.

Function
REQ-017 FSM states shall be IDLE, SETTLE, SAMPLE and DONE.
REQ-018 IDLE with start=1 shall, at that edge, latch expected and clear stim, captured, err_count, first_err, first_err_valid and pass, then enter SETTLE.
REQ-019 SETTLE shall hold stim constant for exactly SETTLE cycles, then enter SAMPLE.
REQ-020 SAMPLE shall write dut_out into captured[stim] and compare it with expected[stim].
REQ-021 On a SAMPLE mismatch, err_count shall increment; if first_err_valid=0, first_err shall load stim and first_err_valid shall be set.
REQ-022 After SAMPLE, if stim == 2**N_IN-1 the FSM shall enter DONE; otherwise stim shall increment by 1 and the FSM shall enter SETTLE.
REQ-023 stim shall never wrap within a sweep.
REQ-024 DONE shall last exactly one cycle with done=1 and pass=(err_count==0, including the final SAMPLE), then return to IDLE.
REQ-025 Timing: done shall rise exactly 2**N_IN*(SETTLE+1) edges after the start-accept edge (24 for the defaults).
REQ-026 start outside IDLE shall be ignored and shall have no effect.
REQ-027 abort=1 in SETTLE or SAMPLE shall force IDLE at the next edge with stim=0 and pass=0.
REQ-028 On abort, done shall not pulse; captured, err_count and first_err shall retain their partial values.
REQ-029 If abort and start are both high in IDLE, start shall win.
REQ-030 pass, captured, err_count, first_err and first_err_valid shall hold their values in IDLE until the next start accept.
REQ-031 err_count shall never saturate, since its maximum is 2**N_IN.

Reset
REQ-032 rst_n=0 shall immediately force IDLE with stim, busy, done, pass, captured, err_count, first_err and first_err_valid all 0, and shall clear the latched expected value.
REQ-033 Reset asserted mid-sweep shall discard all progress; no done pulse shall occur after release.
REQ-034 Reset deassertion needs no start; the block shall remain in IDLE.

Structure
REQ-035 Shared package kmap_pkg shall hold the state enum and the default N_IN and SETTLE constants.
REQ-036 One sub-module, kmap_settle_timer, shall provide the per-vector settle countdown: load on entry to SETTLE, expire flag after SETTLE cycles, asynchronous clear on rst_n.

Verification
REQ-037 Clean sweep: DUT model is majority(a,b,c), expected=8'hE8, start pulsed -> done 24 edges later, pass=1, captured=8'hE8, err_count=0, first_err_valid=0.
REQ-038 Mismatch: same DUT, expected=8'hE9 -> pass=0, err_count=1, first_err=0, first_err_valid=1, captured=8'hE8.
REQ-039 Multiple mismatches: expected=8'h17 (complement of 8'hE8) -> err_count=8, first_err=0, pass=0.
REQ-040 Stray start: start re-pulsed at edges 5 and 23 of a sweep -> ignored; done still at edge 24; stim sequence 0..7 uninterrupted.
REQ-041 Abort: abort pulsed while stim=3 -> next edge busy=0, stim=0, pass=0, no done; captured[2:0] retain their sampled values.
REQ-042 Reset mid-sweep: rst_n low at stim=5 -> all outputs 0 asynchronously; after release, no done until a new start, and a new sweep passes per REQ-037.

Source files
------------

// File: rtl/kmap_pkg.sv
// Shared types and default sizing for the K-map sweep checker.
package kmap_pkg;

    localparam int N_IN_DEF   = 3;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } kmap_state_t;

endpackage

// File: rtl/kmap_settle_timer.sv
// Per-vector settle countdown: loaded on entry to SETTLE, expires after SETTLE cycles.
module kmap_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    // Loading SETTLE-1 makes the zero count coincide with the last settle cycle.
    localparam logic [3:0] LOAD_VAL = 4'(SETTLE - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: load wins, otherwise count down while running.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (run && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/kmap_sweep_checker.sv
// Sweeps every input vector of a small combinational DUT, captures its truth
// table and compares it against an expected table.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// SETTLE | stim held steady while the DUT output settles
// SAMPLE | dut_out captured and compared for the current stim
// DONE   | one-cycle completion pulse, then back to IDLE
module kmap_sweep_checker
    import kmap_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err,
    output logic                 first_err_valid
);

    localparam int N_VEC = 2**N_IN;
    localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};

    kmap_state_t         state_q, state_d;
    logic [N_VEC-1:0]    expected_q, expected_d;
    logic [N_IN-1:0]     stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_VEC-1:0]    captured_q, captured_d;
    logic [N_IN:0]       err_count_q, err_count_d;
    logic [N_IN-1:0]     first_err_q, first_err_d;
    logic                first_err_valid_q, first_err_valid_d;

    logic                timer_load;
    logic                timer_expired;

    kmap_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .run     (state_q == ST_SETTLE),
        .expired (timer_expired)
    );

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_d           = state_q;
        expected_d        = expected_q;
        stim_d            = stim_q;
        done_d            = 1'b0;
        pass_d            = pass_q;
        captured_d        = captured_q;
        err_count_d       = err_count_q;
        first_err_d       = first_err_q;
        first_err_valid_d = first_err_valid_q;
        timer_load        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort here
                if (start) begin
                    expected_d        = expected;
                    stim_d            = '0;
                    captured_d        = '0;
                    err_count_d       = '0;
                    first_err_d       = '0;
                    first_err_valid_d = 1'b0;
                    pass_d            = 1'b0;
                    timer_load        = 1'b1;
                    state_d           = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    stim_d  = '0;
                    pass_d  = 1'b0;
                end else if (timer_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // An abort here drops the current sample; earlier results stay.
                if (abort) begin
                    state_d = ST_IDLE;
                    stim_d  = '0;
                    pass_d  = 1'b0;
                end else begin
                    captured_d[stim_q] = dut_out;
                    if (dut_out != expected_q[stim_q]) begin
                        err_count_d = err_count_q + 1'b1;
                        if (!first_err_valid_q) begin
                            first_err_d       = stim_q;
                            first_err_valid_d = 1'b1;
                        end
                    end
                    if (stim_q == STIM_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == '0);
                    end else begin
                        stim_d     = stim_q + 1'b1;
                        timer_load = 1'b1;
                        state_d    = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    // State and registered outputs; reset clears everything including the latched table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            expected_q        <= '0;
            stim_q            <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            captured_q        <= '0;
            err_count_q       <= '0;
            first_err_q       <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            expected_q        <= expected_d;
            stim_q            <= stim_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            captured_q        <= captured_d;
            err_count_q       <= err_count_d;
            first_err_q       <= first_err_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign stim            = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign captured        = captured_q;
    assign err_count       = err_count_q;
    assign first_err       = first_err_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_kmap_sweep_checker.sv
// Scoreboard bench for kmap_sweep_checker driving a majority(a,b,c) DUT model.
module tb_kmap_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] expected_tt;
    logic       dut_out;
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] captured;
    logic [3:0] err_count;
    logic [2:0] first_err;
    logic       first_err_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic       pass;
        logic [7:0] cap;
        logic [3:0] errs;
        logic [2:0] ferr;
        logic       fv;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    logic done_prev = 1'b0;

    kmap_sweep_checker #(
        .N_IN   (3),
        .SETTLE (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .expected        (expected_tt),
        .dut_out         (dut_out),
        .stim            (stim),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .captured        (captured),
        .err_count       (err_count),
        .first_err       (first_err),
        .first_err_valid (first_err_valid)
    );

    // majority of {a,b,c} = stim[2:0]
    assign dut_out = (stim[2] & stim[1]) | (stim[2] & stim[0]) | (stim[1] & stim[0]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_one_cycle", int'(done_prev), 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle",      cyc,                    e.cyc);
                chk("pass",            int'(pass),             int'(e.pass));
                chk("captured",        int'(captured),         int'(e.cap));
                chk("err_count",       int'(err_count),        int'(e.errs));
                chk("first_err_valid", int'(first_err_valid),  int'(e.fv));
                if (e.fv) chk("first_err", int'(first_err), int'(e.ferr));
            end
        end
        done_prev = done;
    end

    task automatic run_sweep(input logic [7:0] tt, input logic with_abort, input logic push,
                             input logic p, input logic [3:0] errs, input logic [2:0] ferr,
                             input logic fv);
        exp_t e;
        @(negedge clk);
        start       = 1'b1;
        abort       = with_abort;
        expected_tt = tt;
        e.pass = p; e.cap = 8'hE8; e.errs = errs; e.ferr = ferr; e.fv = fv;
        e.cyc  = cyc + 1 + 24;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk);
        end
        chk({"wait_", name}, sb.size(), 0);
        chk({"idle_", name}, int'(busy), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        expected_tt = 8'h00;
        #1;
        chk("rst_busy",      int'(busy),            0);
        chk("rst_done",      int'(done),            0);
        chk("rst_stim",      int'(stim),            0);
        chk("rst_pass",      int'(pass),            0);
        chk("rst_captured",  int'(captured),        0);
        chk("rst_err_count", int'(err_count),       0);
        chk("rst_fv",        int'(first_err_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_release", int'(busy), 0);

        // clean sweep
        run_sweep(8'hE8, 1'b0, 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
        wait_idle("clean");
        // single mismatch at vector 0
        run_sweep(8'hE9, 1'b0, 1'b1, 1'b0, 4'd1, 3'd0, 1'b1);
        wait_idle("mis_e9");
        // every vector mismatches
        run_sweep(8'h17, 1'b0, 1'b1, 1'b0, 4'd8, 3'd0, 1'b1);
        wait_idle("mis_17");
        // mismatch at vector 3 only
        run_sweep(8'hE0, 1'b0, 1'b1, 1'b0, 4'd1, 3'd3, 1'b1);
        wait_idle("mis_e0");
        // mismatch only on the final vector: pass must include the last sample
        run_sweep(8'h68, 1'b0, 1'b1, 1'b0, 4'd1, 3'd7, 1'b1);
        wait_idle("mis_68");
        // results hold in IDLE
        repeat (5) @(negedge clk);
        chk("hold_err_count", int'(err_count), 1);
        chk("hold_first_err", int'(first_err), 7);
        // start and abort together in IDLE: start wins
        run_sweep(8'hE8, 1'b1, 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
        wait_idle("start_wins");

        // stray starts at edges 5 and 23
        run_sweep(8'hE8, 1'b0, 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k < 24) chk("stray_stim_seq", int'(stim), k / 3);
            if (k == 4 || k == 22) start = 1'b1;
            if (k == 5 || k == 23) start = 1'b0;
        end
        wait_idle("stray");

        // abort at stim=3 with all-ones expectation (vectors 0..2 mismatch)
        run_sweep(8'hFF, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        for (int i = 0; i < 100 && stim != 3'd3; i++) @(negedge clk);
        chk("abort_reach_stim3", int'(stim), 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",      int'(busy),            0);
        chk("abort_stim",      int'(stim),            0);
        chk("abort_pass",      int'(pass),            0);
        chk("abort_cap_lo",    int'(captured[2:0]),   0);
        chk("abort_err_count", int'(err_count),       3);
        chk("abort_first_err", int'(first_err),       0);
        chk("abort_fv",        int'(first_err_valid), 1);
        repeat (30) @(negedge clk);
        chk("abort_hold_errs", int'(err_count), 3);

        // reset mid-sweep at stim=5
        run_sweep(8'hE8, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        for (int i = 0; i < 100 && stim != 3'd5; i++) @(negedge clk);
        chk("rst_reach_stim5", int'(stim), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      int'(busy),            0);
        chk("mid_rst_stim",      int'(stim),            0);
        chk("mid_rst_done",      int'(done),            0);
        chk("mid_rst_pass",      int'(pass),            0);
        chk("mid_rst_captured",  int'(captured),        0);
        chk("mid_rst_err_count", int'(err_count),       0);
        chk("mid_rst_first_err", int'(first_err),       0);
        chk("mid_rst_fv",        int'(first_err_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);
        run_sweep(8'hE8, 1'b0, 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
        wait_idle("post_rst_clean");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
